mem_mailbox: RTL and testbench

//  Memory-mapped mailbox on the CPU data bus. The CPU is the initiator and this block is the responder.
//  A CPU write to TXDATA pushes a word into a TX FIFO; an external consumer drains it over a valid/ready port.
//  An external producer fills an RX FIFO over a valid/ready port; a CPU read of RXDATA pops one word.

---
 rtl/mem_mailbox_if.sv | 28 ++
 rtl/mem_mailbox.sv | 190 +++++++++++++++++++
 tb/tb_mem_mailbox.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_mailbox_if.sv
// CPU data-bus access plus TX/RX valid/ready streams for mem_mailbox.
// slave is the mailbox side; master is the CPU, producer and consumer side.
interface mem_mailbox_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
);
  logic          cen;
  logic [AW-1:0] addr;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport slave (
    input  cen, addr, wen, wdata, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );

  modport master (
    output cen, addr, wen, wdata, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mem_mailbox.sv
// Memory-mapped mailbox: CPU-written TX FIFO and CPU-read RX FIFO with valid/ready streams.
// Define MBOX_IRQ_EN to add the IRQ_EN register and the registered irq output.
module mem_mailbox #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 10
) (
  input  logic         clk,
  input  logic         reset,
  mem_mailbox_if.slave bus
`ifdef MBOX_IRQ_EN
  ,
  output logic         irq
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    A_TXDATA = 3'd0,
    A_RXDATA = 3'd1,
    A_STATUS = 3'd2,
    A_CTRL   = 3'd3,
    A_IRQ_EN = 3'd4
  } reg_e;

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];

  logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef MBOX_IRQ_EN
  logic [1:0]    irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
`endif

  logic [2:0]    reg_sel;
  logic          cpu_wr, cpu_rd, ctrl_wr;
  logic          tx_push_req, rx_pop_req;
  logic          tx_flush, rx_flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [DW-1:0] status;
  logic          unused_addr;

  assign reg_sel     = bus.addr[2:0];
  assign unused_addr = ^bus.addr[AW-1:3];

  assign cpu_wr      = bus.cen & bus.wen;
  assign cpu_rd      = bus.cen & ~bus.wen;
  assign ctrl_wr     = cpu_wr & (reg_sel == A_CTRL);
  assign tx_push_req = cpu_wr & (reg_sel == A_TXDATA);
  assign rx_pop_req  = cpu_rd & (reg_sel == A_RXDATA);
  assign tx_flush    = ctrl_wr & bus.wdata[0];
  assign rx_flush    = ctrl_wr & bus.wdata[1];

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  // A full TX still accepts a push when the consumer frees a slot on the same edge.
  assign tx_pop  = ~tx_empty & bus.tx_ready;
  assign tx_push = tx_push_req & (~tx_full | tx_pop);
  assign rx_push = bus.rx_valid & ~rx_full;
  assign rx_pop  = rx_pop_req & ~rx_empty;

  assign bus.tx_data  = tx_mem[tx_rptr_q];
  assign bus.tx_valid = ~tx_empty;
  assign bus.rx_ready = ~rx_full;
  assign bus.rdata    = rdata_q;
`ifdef MBOX_IRQ_EN
  assign irq          = irq_q;
`endif

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
      if (tx_push & ~tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
      else if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    end
    tx_ovf_d = (tx_ovf_q & ~(ctrl_wr & bus.wdata[2]))
             | (tx_push_req & tx_full & ~tx_pop);
  end

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
      if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
      else if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    end
    rx_udf_d = (rx_udf_q & ~(ctrl_wr & bus.wdata[3]))
             | (rx_pop_req & rx_empty);
  end

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = tx_ovf_q;
    status[5]     = rx_udf_q;
    status[15:8]  = 8'(tx_cnt_q);
    status[23:16] = 8'(rx_cnt_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cpu_rd) begin
      rdata_d = '0;
      case (reg_sel)
        A_RXDATA: if (~rx_empty) rdata_d = rx_mem[rx_rptr_q];
        A_STATUS: rdata_d = status;
`ifdef MBOX_IRQ_EN
        A_IRQ_EN: rdata_d[1:0] = irq_en_q;
`endif
        default:  rdata_d = '0;
      endcase
    end
  end

`ifdef MBOX_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (cpu_wr & (reg_sel == A_IRQ_EN)) irq_en_d = bus.wdata[1:0];
    irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
  end
`endif

  // Storage has no reset; only pointers and counts define its contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= bus.wdata;
    if (rx_push & ~rx_flush) rx_mem[rx_wptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_udf_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef MBOX_IRQ_EN
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_udf_q  <= rx_udf_d;
      rdata_q   <= rdata_d;
`ifdef MBOX_IRQ_EN
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_mailbox.sv
// Randomized scoreboard bench for mem_mailbox against a queue-based mailbox model.
module tb_mem_mailbox;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef MBOX_IRQ_EN
  logic irq;
  logic [1:0] m_en = 2'b00;
  logic m_irq = 1'b0;
`endif

  mem_mailbox_if #(.DW(32), .AW(10)) bus ();

  mem_mailbox #(.DEPTH(DEPTH), .DW(32), .AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MBOX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [31:0] exp_rd[$];
  logic [31:0] last_rd = '0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (txq.size() == DEPTH);
    s[1] = (txq.size() == 0);
    s[2] = (rxq.size() == DEPTH);
    s[3] = (rxq.size() == 0);
    s[4] = m_ovf;
    s[5] = m_udf;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    exp_rd.delete();
    last_rd = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
`ifdef MBOX_IRQ_EN
    m_en = 2'b00;
    m_irq = 1'b0;
`endif
  endtask

  // Drives one cycle of inputs (called 2 time units after a rising edge), updates the
  // model to its post-edge state, queues any expected read data, then waits for the edge.
  task automatic step(input bit c, input logic [2:0] a, input bit w, input logic [31:0] d,
                      input bit trdy, input bit rvld, input logic [31:0] rd);
    bit tx_pop, rx_push;
    logic [31:0] rv;
    bus.cen = c; bus.addr = {7'b0, a}; bus.wen = w; bus.wdata = d;
    bus.tx_ready = trdy; bus.rx_valid = rvld; bus.rx_data = rd;
    tx_pop  = trdy && (txq.size() != 0);
    rx_push = rvld && (rxq.size() < DEPTH);
`ifdef MBOX_IRQ_EN
    m_irq = (m_en[0] && rxq.size() != 0) || (m_en[1] && txq.size() == 0);
`endif
    if (c && !w) begin
      rv = '0;
      if (a == 3'd1 && rxq.size() != 0) rv = rxq[0];
      else if (a == 3'd2) rv = model_status();
`ifdef MBOX_IRQ_EN
      else if (a == 3'd4) rv = {30'b0, m_en};
      if (c && w && a == 3'd4) m_en = d[1:0];
`endif
      exp_rd.push_back(rv);
    end
`ifdef MBOX_IRQ_EN
    if (c && w && a == 3'd4) m_en = d[1:0];
`endif
    if (c && w && a == 3'd3) begin
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_udf = 1'b0;
    end
    if (c && w && a == 3'd3 && d[0]) txq.delete();
    else begin
      if (tx_pop) void'(txq.pop_front());
      if (c && w && a == 3'd0) begin
        if (txq.size() < DEPTH) txq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    if (c && w && a == 3'd3 && d[1]) rxq.delete();
    else begin
      if (c && !w && a == 3'd1) begin
        if (rxq.size() != 0) void'(rxq.pop_front());
        else m_udf = 1'b1;
      end
      if (rx_push) rxq.push_back(rd);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit trdy);
    step(1'b0, 3'd0, 1'b0, '0, trdy, 1'b0, '0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input bit trdy);
    step(1'b1, a, 1'b1, d, trdy, 1'b0, '0);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, a, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compares DUT outputs with the model one time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus.cen && !bus.wen) begin
          if (exp_rd.size() == 0) chk("rd_queue_underrun", 32'd1, 32'd0);
          else last_rd = exp_rd.pop_front();
        end
        chk("rdata", bus.rdata, last_rd);
        chk("tx_valid", 32'(bus.tx_valid), 32'(txq.size() != 0));
        chk("rx_ready", 32'(bus.rx_ready), 32'(rxq.size() < DEPTH));
        if (bus.tx_valid && txq.size() != 0) chk("tx_data", bus.tx_data, txq[0]);
`ifdef MBOX_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
      end
    end
  end

  initial begin
    bus.cen = 1'b0; bus.addr = '0; bus.wen = 1'b0; bus.wdata = '0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("reset_rdata", bus.rdata, 32'd0);
    @(posedge clk);
    #2;
    mon_en = 1'b1;

    rd(3'd2);
    chk("status_after_reset", bus.rdata, 32'h0000_000A);

    wr(3'd0, 32'h11, 1'b0);
    wr(3'd0, 32'h22, 1'b0);
    wr(3'd0, 32'h33, 1'b0);
    rd(3'd2);
    chk("status_tx3", bus.rdata, 32'h0000_0308);
    chk("drain_0", bus.tx_data, 32'h11);
    idle(1'b1);
    chk("drain_1", bus.tx_data, 32'h22);
    idle(1'b1);
    chk("drain_2", bus.tx_data, 32'h33);
    idle(1'b1);
    chk("drain_done_valid", 32'(bus.tx_valid), 32'd0);

    for (int i = 0; i < 9; i++) wr(3'd0, 32'h100 + 32'(i), 1'b0);
    rd(3'd2);
    chk("status_tx_ovf", bus.rdata, 32'h0000_0819);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("ovf_drained", 32'(bus.tx_valid), 32'd0);
    wr(3'd3, 32'h4, 1'b0);
    for (int i = 0; i < 8; i++) wr(3'd0, 32'h200 + 32'(i), 1'b0);
    wr(3'd0, 32'h208, 1'b1);
    rd(3'd2);
    chk("status_full_pop_push", bus.rdata, 32'h0000_0809);
    wr(3'd3, 32'h1, 1'b0);

    for (int i = 1; i <= 8; i++) step(1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b1, 32'hA5A5_0000 + 32'(i));
    chk("rx_full_ready", 32'(bus.rx_ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      rd(3'd1);
      chk("rx_pop_order", bus.rdata, 32'hA5A5_0000 + 32'(i));
    end
    rd(3'd1);
    chk("rx_underflow_data", bus.rdata, 32'd0);
    rd(3'd2);
    chk("status_rx_udf", bus.rdata, 32'h0000_002A);
    wr(3'd3, 32'h8, 1'b0);
    rd(3'd2);
    chk("status_udf_cleared", bus.rdata, 32'h0000_000A);

    for (int i = 0; i < 5; i++) wr(3'd0, 32'h300 + 32'(i), 1'b0);
    wr(3'd3, 32'h1, 1'b1);
    chk("flush_tx_valid", 32'(bus.tx_valid), 32'd0);
    for (int i = 0; i < 5; i++) wr(3'd0, 32'h400 + 32'(i), 1'b0);
    rd(3'd2);
    chk("status_tx5", bus.rdata, 32'h0000_0508);
    idle(1'b1);
    idle(1'b1);
    mon_en = 1'b0;
    bus.cen = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midreset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midreset_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("midreset_rdata", bus.rdata, 32'd0);
`ifdef MBOX_IRQ_EN
    chk("midreset_irq", 32'(irq), 32'd0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    rd(3'd2);
    chk("status_after_midreset", bus.rdata, 32'h0000_000A);

`ifdef MBOX_IRQ_EN
    wr(3'd4, 32'h1, 1'b0);
    idle(1'b0);
    step(1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b1, 32'hBEEF);
    chk("irq_lag_rise", 32'(irq), 32'd0);
    idle(1'b0);
    chk("irq_high", 32'(irq), 32'd1);
    rd(3'd1);
    chk("irq_hold_on_pop", 32'(irq), 32'd1);
    idle(1'b0);
    chk("irq_low", 32'(irq), 32'd0);
    wr(3'd4, 32'h0, 1'b0);
`endif

    for (int blk = 0; blk < 15; blk++) begin
      int p_tx, p_rx, p_cen;
      p_tx  = $urandom_range(0, 100);
      p_rx  = $urandom_range(0, 100);
      p_cen = $urandom_range(20, 100);
      for (int n = 0; n < 200; n++) begin
        int r;
        logic [2:0] a;
        logic [31:0] d;
        bit w;
        r = $urandom_range(0, 99);
        if (r < 30) a = 3'd0;
        else if (r < 55) a = 3'd1;
        else if (r < 70) a = 3'd2;
        else if (r < 76) a = 3'd3;
        else if (r < 84) a = 3'd4;
        else a = 3'($urandom_range(5, 7));
        w = ($urandom_range(0, 1) == 1);
        d = $urandom;
        if (a == 3'd3 && $urandom_range(0, 3) != 0) d = d & 32'hC;
        step(($urandom_range(0, 99) < p_cen), a, w, d,
             ($urandom_range(0, 99) < p_tx), ($urandom_range(0, 99) < p_rx), $urandom);
      end
    end

    idle(1'b0);
    idle(1'b0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
